// File: rtl/mem_controller_if.sv
// rtl/mem_controller_if.sv - LSU-side and memory-side handshake bundle for mem_controller
// master is the controller's view; slave is the LSU/memory environment's view.
interface mem_controller_if #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
);
  logic [NUM_CONSUMERS-1:0]           consumer_read_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address;
  logic [NUM_CONSUMERS-1:0]           consumer_read_ready;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_valid;
  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data;
  logic [NUM_CONSUMERS-1:0]           consumer_write_ready;
  logic                               mem_read_valid;
  logic [ADDR_BITS-1:0]               mem_read_address;
  logic                               mem_read_ready;
  logic [DATA_BITS-1:0]               mem_read_data;
  logic                               mem_write_valid;
  logic [ADDR_BITS-1:0]               mem_write_address;
  logic [DATA_BITS-1:0]               mem_write_data;
  logic                               mem_write_ready;

  modport master (
    input  consumer_read_valid, consumer_read_address,
    input  consumer_write_valid, consumer_write_address, consumer_write_data,
    input  mem_read_ready, mem_read_data, mem_write_ready,
    output consumer_read_ready, consumer_read_data, consumer_write_ready,
    output mem_read_valid, mem_read_address,
    output mem_write_valid, mem_write_address, mem_write_data
  );

  modport slave (
    output consumer_read_valid, consumer_read_address,
    output consumer_write_valid, consumer_write_address, consumer_write_data,
    output mem_read_ready, mem_read_data, mem_write_ready,
    input  consumer_read_ready, consumer_read_data, consumer_write_ready,
    input  mem_read_valid, mem_read_address,
    input  mem_write_valid, mem_write_address, mem_write_data
  );
endinterface

// File: rtl/mem_controller.sv
// rtl/mem_controller.sv - round-robin arbiter of per-LSU loads/stores onto one data-memory port
// One memory transaction in flight; a consumer requesting both read and write gets the read first.
module mem_controller #(
  parameter int NUM_CONSUMERS = 4,
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8
) (
  input logic             clk,
  input logic             reset,
  mem_controller_if.master bus
);
  localparam int IDX_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CONSUMERS - 1);

  typedef enum logic [1:0] {IDLE, READ_WAITING, WRITE_WAITING, RELAYING} state_e;

  state_e                             state_q;
  logic [IDX_W-1:0]                   grant_q;
  logic [IDX_W-1:0]                   rr_q;
  logic [IDX_W-1:0]                   rr_d;
  logic                               is_read_q;
  logic [NUM_CONSUMERS-1:0]           rd_ready_q;
  logic [NUM_CONSUMERS-1:0]           wr_ready_q;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_q;
  logic                               mem_rv_q;
  logic                               mem_wv_q;
  logic [ADDR_BITS-1:0]               mem_ra_q;
  logic [ADDR_BITS-1:0]               mem_wa_q;
  logic [DATA_BITS-1:0]               mem_wd_q;

  logic                               sel_found;
  logic                               sel_read;
  logic [IDX_W-1:0]                   sel_idx;
  logic [IDX_W-1:0]                   cand;

  // First requester at or above the rr pointer, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_read  = 1'b0;
    sel_idx   = rr_q;
    cand      = rr_q;
    for (int k = 0; k < NUM_CONSUMERS; k++) begin
      if (!sel_found && (bus.consumer_read_valid[cand] || bus.consumer_write_valid[cand])) begin
        sel_found = 1'b1;
        sel_idx   = cand;
        sel_read  = bus.consumer_read_valid[cand];
      end
      cand = (cand == LAST_IDX) ? '0 : cand + IDX_W'(1);
    end
  end

  assign rr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_q       <= '0;
      is_read_q  <= 1'b0;
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      rd_data_q  <= '0;
      mem_rv_q   <= 1'b0;
      mem_wv_q   <= 1'b0;
      mem_ra_q   <= '0;
      mem_wa_q   <= '0;
      mem_wd_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_found) begin
            grant_q   <= sel_idx;
            is_read_q <= sel_read;
            if (sel_read) begin
              mem_rv_q <= 1'b1;
              mem_ra_q <= bus.consumer_read_address[sel_idx*ADDR_BITS +: ADDR_BITS];
              state_q  <= READ_WAITING;
            end else begin
              mem_wv_q <= 1'b1;
              mem_wa_q <= bus.consumer_write_address[sel_idx*ADDR_BITS +: ADDR_BITS];
              mem_wd_q <= bus.consumer_write_data[sel_idx*DATA_BITS +: DATA_BITS];
              state_q  <= WRITE_WAITING;
            end
          end
        end
        READ_WAITING: begin
          if (bus.mem_read_ready) begin
            mem_rv_q <= 1'b0;
            rd_data_q[grant_q*DATA_BITS +: DATA_BITS] <= bus.mem_read_data;
            // A consumer that withdrew its request gets no ready pulse.
            if (bus.consumer_read_valid[grant_q]) begin
              rd_ready_q[grant_q] <= 1'b1;
              state_q             <= RELAYING;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        WRITE_WAITING: begin
          if (bus.mem_write_ready) begin
            mem_wv_q <= 1'b0;
            if (bus.consumer_write_valid[grant_q]) begin
              wr_ready_q[grant_q] <= 1'b1;
              state_q             <= RELAYING;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        RELAYING: begin
          if (is_read_q ? !bus.consumer_read_valid[grant_q] : !bus.consumer_write_valid[grant_q]) begin
            rd_ready_q <= '0;
            wr_ready_q <= '0;
            rr_q       <= rr_d;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.consumer_read_ready  = rd_ready_q;
  assign bus.consumer_read_data   = rd_data_q;
  assign bus.consumer_write_ready = wr_ready_q;
  assign bus.mem_read_valid       = mem_rv_q;
  assign bus.mem_read_address     = mem_ra_q;
  assign bus.mem_write_valid      = mem_wv_q;
  assign bus.mem_write_address    = mem_wa_q;
  assign bus.mem_write_data       = mem_wd_q;
endmodule

// File: tb/tb_mem_controller.sv
// tb/tb_mem_controller.sv - directed scoreboard bench for mem_controller
// Memory responder, LSU auto-release and monitors all run inside cycle(), 1 time unit after each rising edge.
module tb_mem_controller;
  localparam int N = 4;
  localparam int A = 8;
  localparam int D = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_controller_if #(.NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D)) bus();
  mem_controller #(.NUM_CONSUMERS(N), .ADDR_BITS(A), .DATA_BITS(D)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct packed {
    logic         wr;
    logic [A-1:0] addr;
    logic [D-1:0] data;
  } txn_t;

  txn_t         sb_q[$];
  int           done_log[$];
  logic [D-1:0] memarr[256];
  logic [D-1:0] exp_rdata[N];
  int checks = 0, failures = 0;
  int lat = 1, rcnt = 0, wcnt = 0, done_cnt = 0;
  logic prev_rv = 1'b0, prev_wv = 1'b0;
  logic any_rd_ready = 1'b0, rd3_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_txn(input logic wr, input logic [A-1:0] addr, input logic [D-1:0] data);
    txn_t t;
    if (sb_q.size() == 0) begin
      chk("sb_unexpected_txn", 32'(addr), 32'hFFFF_FFFF);
    end else begin
      t = sb_q.pop_front();
      chk("txn_type", 32'(wr), 32'(t.wr));
      chk("txn_addr", 32'(addr), 32'(t.addr));
      if (wr) chk("txn_wdata", 32'(data), 32'(t.data));
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    if (bus.mem_read_ready) begin
      bus.mem_read_ready = 1'b0; rcnt = 0;
    end else if (bus.mem_read_valid) begin
      rcnt++;
      if (rcnt >= lat) begin
        bus.mem_read_ready = 1'b1;
        bus.mem_read_data  = memarr[bus.mem_read_address];
      end
    end else rcnt = 0;
    if (bus.mem_write_ready) begin
      bus.mem_write_ready = 1'b0; wcnt = 0;
    end else if (bus.mem_write_valid) begin
      wcnt++;
      if (wcnt >= lat) begin
        bus.mem_write_ready = 1'b1;
        memarr[bus.mem_write_address] = bus.mem_write_data;
      end
    end else wcnt = 0;
    chk("mem_valid_exclusive", 32'(bus.mem_read_valid & bus.mem_write_valid), 0);
    chk("ready_onehot", 32'($countones({bus.consumer_read_ready, bus.consumer_write_ready}) <= 1), 1);
    if (bus.mem_read_valid && !prev_rv) new_txn(1'b0, bus.mem_read_address, '0);
    if (bus.mem_write_valid && !prev_wv) new_txn(1'b1, bus.mem_write_address, bus.mem_write_data);
    prev_rv = bus.mem_read_valid;
    prev_wv = bus.mem_write_valid;
    if (bus.consumer_read_ready != 0) any_rd_ready = 1'b1;
    if (bus.consumer_read_ready[3]) rd3_seen = 1'b1;
    for (int c = 0; c < N; c++) begin
      if (bus.consumer_read_ready[c] && bus.consumer_read_valid[c]) begin
        chk($sformatf("rdata_c%0d", c), 32'(bus.consumer_read_data[c*D +: D]), 32'(exp_rdata[c]));
        done_log.push_back(c);
        bus.consumer_read_valid[c] = 1'b0;
        done_cnt++;
      end
      if (bus.consumer_write_ready[c] && bus.consumer_write_valid[c]) begin
        done_log.push_back(c + 8);
        bus.consumer_write_valid[c] = 1'b0;
        done_cnt++;
      end
    end
  endtask

  task automatic rd_req(input int c, input logic [A-1:0] addr);
    bus.consumer_read_valid[c] = 1'b1;
    bus.consumer_read_address[c*A +: A] = addr;
    exp_rdata[c] = memarr[addr];
    sb_q.push_back('{wr: 1'b0, addr: addr, data: '0});
  endtask

  task automatic wr_req(input int c, input logic [A-1:0] addr, input logic [D-1:0] data);
    bus.consumer_write_valid[c] = 1'b1;
    bus.consumer_write_address[c*A +: A] = addr;
    bus.consumer_write_data[c*D +: D] = data;
    sb_q.push_back('{wr: 1'b1, addr: addr, data: data});
  endtask

  task automatic start_test();
    done_log.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(input int n, input int budget);
    int b = 0;
    while (done_cnt < n && b < budget) begin
      cycle();
      b++;
    end
    chk("completion_timeout", 32'(done_cnt >= n), 1);
  endtask

  task automatic wait_mem_rv(input int budget);
    int b = 0;
    while (!bus.mem_read_valid && b < budget) begin
      cycle();
      b++;
    end
    chk("mem_read_valid_timeout", 32'(bus.mem_read_valid), 1);
  endtask

  task automatic chk_order(input string tag, input int exp[$]);
    chk({tag, "_count"}, 32'(done_log.size()), 32'(exp.size()));
    for (int k = 0; k < exp.size() && k < done_log.size(); k++)
      chk($sformatf("%s_%0d", tag, k), 32'(done_log[k]), 32'(exp[k]));
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 256; i++) memarr[i] = 8'(i * 7 + 3);
    memarr[8'h3C] = 8'hA5;
    for (int c = 0; c < N; c++) exp_rdata[c] = '0;
    bus.consumer_read_valid    = '0;
    bus.consumer_read_address  = '0;
    bus.consumer_write_valid   = '0;
    bus.consumer_write_address = '0;
    bus.consumer_write_data    = '0;
    bus.mem_read_ready         = 1'b0;
    bus.mem_read_data          = '0;
    bus.mem_write_ready        = 1'b0;
    repeat (2) cycle();
    chk("rst_mem_read_valid", 32'(bus.mem_read_valid), 0);
    chk("rst_mem_write_valid", 32'(bus.mem_write_valid), 0);
    chk("rst_read_ready", 32'(bus.consumer_read_ready), 0);
    chk("rst_write_ready", 32'(bus.consumer_write_ready), 0);
    chk("rst_read_data", 32'(bus.consumer_read_data), 0);
    chk("rst_mem_addr", 32'({bus.mem_read_address, bus.mem_write_address, bus.mem_write_data}), 0);
    reset = 1'b0;

    // Single read from consumer 2, memory answers three cycles after valid.
    start_test();
    lat = 3;
    cycle();
    rd_req(2, 8'h3C);
    cycle();
    chk("t1_valid_latency", 32'(bus.mem_read_valid), 1);
    wait_done(1, 20);
    cycle();
    chk("t1_ready_dropped", 32'(bus.consumer_read_ready), 0);
    chk("t1_data_held", 32'(bus.consumer_read_data[2*D +: D]), 32'h0A5);

    // Single write from consumer 1.
    start_test();
    lat = 2;
    any_rd_ready = 1'b0;
    wr_req(1, 8'h10, 8'h7E);
    wait_done(1, 20);
    cycle();
    chk("t2_wr_ready_dropped", 32'(bus.consumer_write_ready), 0);
    chk("t2_no_read_ready", 32'(any_rd_ready), 0);
    chk("t2_order", 32'(done_log[0]), 9);
    chk("t2_mem_written", 32'(memarr[8'h10]), 32'h7E);

    reset = 1'b1;
    cycle();
    reset = 1'b0;

    // All four read together: grants rotate 0..3, then 0 and 3 with pointer wrapped.
    start_test();
    lat = 1;
    for (int c = 0; c < N; c++) rd_req(c, 8'(c));
    wait_done(4, 60);
    chk_order("t3_rr", '{0, 1, 2, 3});
    cycle();
    start_test();
    rd_req(0, 8'h40);
    rd_req(3, 8'h43);
    wait_done(2, 30);
    chk_order("t3_wrap", '{0, 3});
    cycle();

    // Read wins over simultaneous write from the same consumer.
    start_test();
    rd_req(0, 8'h20);
    wr_req(0, 8'h21, 8'h55);
    wait_done(2, 30);
    chk_order("t4_prio", '{0, 8});
    chk("t4_mem_written", 32'(memarr[8'h21]), 32'h55);
    cycle();

    // Consumer 3 abandons its read; consumer 1 is served next.
    start_test();
    lat = 3;
    rd3_seen = 1'b0;
    rd_req(3, 8'h33);
    wait_mem_rv(10);
    bus.consumer_read_valid[3] = 1'b0;
    rd_req(1, 8'h11);
    wait_done(1, 30);
    chk("t5_no_ready3", 32'(rd3_seen), 0);
    chk_order("t5_next", '{1});
    chk("t5_abandoned_data", 32'(bus.consumer_read_data[3*D +: D]), 32'(memarr[8'h33]));
    cycle();

    // Asynchronous reset while a read is outstanding.
    start_test();
    lat = 8;
    rd_req(2, 8'h50);
    wait_mem_rv(10);
    cycle();
    #3;
    reset = 1'b1;
    #1;
    chk("t6_async_rv", 32'(bus.mem_read_valid), 0);
    chk("t6_async_ready", 32'({bus.consumer_read_ready, bus.consumer_write_ready}), 0);
    bus.consumer_read_valid[2] = 1'b0;
    repeat (2) cycle();
    reset = 1'b0;
    rd_req(0, 8'h60);
    rd_req(3, 8'h63);
    wait_done(2, 40);
    chk_order("t6_after_reset", '{0, 3});
    cycle();

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
